// File: rtl/pdp6_pkg.sv
// Shared types, opcodes and FSM/console encodings for the simplified PDP-6.
package pdp6_pkg;
  typedef logic [35:0] word_t;
  typedef logic [17:0] addr_t;

  typedef struct packed {
    logic [8:0]  op;
    logic [3:0]  ac;
    logic        i;
    logic [3:0]  x;
    logic [17:0] y;
  } instr_t;

  localparam logic [8:0] OP_MOVE  = 9'o200;
  localparam logic [8:0] OP_MOVEI = 9'o201;
  localparam logic [8:0] OP_MOVEM = 9'o202;
  localparam logic [8:0] OP_JRST  = 9'o254;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EA    = 3'd2;
  localparam logic [2:0] S_IND   = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_START = 3'd1;
  localparam logic [2:0] C_CONT  = 3'd2;
  localparam logic [2:0] C_EXEC  = 3'd3;
  localparam logic [2:0] C_EX    = 3'd4;
  localparam logic [2:0] C_EXN   = 3'd5;
  localparam logic [2:0] C_DEP   = 3'd6;
  localparam logic [2:0] C_DEPN  = 3'd7;

  // One level of effective-address calculation; index 0 means no indexing.
  function automatic addr_t calc_e(word_t w, word_t xv);
    return w[17:0] + ((w[21:18] != 4'd0) ? xv[17:0] : 18'd0);
  endfunction
endpackage

// File: rtl/pdp6_mem.sv
// Fast memory + core: address decode, optional relocation (PDP6_RELOC_EN),
// combinational read mux and write ports.
module pdp6_mem import pdp6_pkg::*; #(
  parameter int CORE_AW = 14
) (
  input  logic        clk,
  input  logic [17:0] addr,
  input  logic        we,
  input  logic [35:0] wdata,
  output logic [35:0] rdata,
  output logic        viol,
  input  logic        user_mode,
  input  logic [7:0]  pr,
  input  logic [7:0]  rlr,
  input  logic [3:0]  xa,
  output logic [35:0] xdata,
  input  logic [3:0]  aca,
  output logic [35:0] acdata,
  input  logic        ffwe,
  input  logic [3:0]  ffwa,
  input  logic [35:0] ffwd
);
  logic [35:0] ff   [0:15];
  logic [35:0] core [0:(1<<CORE_AW)-1];
  logic        is_ff;
  logic [17:0] phys;

  assign is_ff = (addr <= 18'o17);

`ifdef PDP6_RELOC_EN
  assign viol = user_mode && !is_ff && (addr[17:10] > pr);
  assign phys = (user_mode && !is_ff) ? addr + {rlr, 10'b0} : addr;
  logic unused_mem;
  assign unused_mem = ^phys[17:CORE_AW];
`else
  assign viol = 1'b0;
  assign phys = addr;
  logic unused_mem;
  assign unused_mem = ^{user_mode, pr, rlr, phys[17:CORE_AW]};
`endif

  assign rdata  = is_ff ? ff[addr[3:0]] : core[phys[CORE_AW-1:0]];
  assign xdata  = ff[xa];
  assign acdata = ff[aca];

  always_ff @(posedge clk) begin
    if (we && !viol) begin
      if (is_ff) ff[addr[3:0]] <= wdata;
      else       core[phys[CORE_AW-1:0]] <= wdata;
    end
    if (ffwe) ff[ffwa] <= ffwd;
  end
endmodule

// File: rtl/pdp6_system.sv
// Simplified PDP-6 processor with console and memories.
// Define PDP6_RELOC_EN to enable user-mode protection/relocation.
module pdp6_system import pdp6_pkg::*; #(
  parameter int CORE_AW = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_start, key_read_in, key_exec, key_inst_cont, key_mem_cont,
  input  logic        key_inst_stop, key_mem_stop, key_ex, key_ex_nxt, key_dep, key_dep_nxt,
  input  logic        key_io_reset,
  input  logic        sw_power,
  input  logic        sw_addr_stop,
  input  logic [35:0] datasw,
  input  logic [17:0] mas,
  input  logic        user_mode,
  input  logic [7:0]  pr,
  input  logic [7:0]  rlr,
  input  logic        sw_repeat, sw_mem_disable, sw_split_cyc, sw_rim_maint,
  input  logic        sw_repeat_bypass, sw_art3_maint, sw_sct_maint,
  output logic        run,
  output logic [17:0] pc,
  output logic [17:0] ma,
  output logic [35:0] mb,
  output logic        pv
);
  logic [10:0] keys, keys_q, kp;
  logic p_start, p_rdin, p_exec, p_icont, p_mcont, p_ex, p_exn, p_dep, p_depn, p_istop, p_mstop;
  logic unused_sw;

  assign keys = {key_start, key_read_in, key_exec, key_inst_cont, key_mem_cont,
                 key_ex, key_ex_nxt, key_dep, key_dep_nxt, key_inst_stop, key_mem_stop};
  assign kp = keys & ~keys_q;
  assign {p_start, p_rdin, p_exec, p_icont, p_mcont, p_ex, p_exn, p_dep, p_depn, p_istop, p_mstop} = kp;
  assign unused_sw = ^{key_io_reset, sw_repeat, sw_mem_disable, sw_split_cyc, sw_rim_maint,
                       sw_repeat_bypass, sw_art3_maint, sw_sct_maint};

  logic [2:0] state, cmd;
  instr_t     ir;
  addr_t      e, maddr;
  logic       xct, stop_req, astop;
  word_t      rdata, xdata, acdata, mwd, ffwd;
  logic       viol, mwe, ffwe, hit, mem_op, halt_op, stop_now;
  logic [3:0] xa;

  always_comb begin
    cmd = C_NONE;
    if (state == S_IDLE && !run) begin
      if (p_start || p_rdin)       cmd = C_START;
      else if (p_exec)             cmd = C_EXEC;
      else if (p_icont || p_mcont) cmd = C_CONT;
      else if (p_ex)               cmd = C_EX;
      else if (p_exn)              cmd = C_EXN;
      else if (p_dep)              cmd = C_DEP;
      else if (p_depn)             cmd = C_DEPN;
    end
  end

  assign mem_op  = (ir.op == OP_MOVE) || (ir.op == OP_MOVEM);
  assign halt_op = !(mem_op || ir.op == OP_MOVEI || ir.op == OP_JRST) ||
                   (ir.op == OP_JRST && ir.ac != 4'd0);
  assign hit      = sw_addr_stop && (maddr == mas);
  assign stop_now = stop_req || p_istop || p_mstop || astop;
  assign ffwd     = (ir.op == OP_MOVEI) ? {18'b0, e} : rdata;

  always_comb begin
    maddr = pc;
    mwe   = 1'b0;
    mwd   = datasw;
    ffwe  = 1'b0;
    xa    = ir.x;
    case (state)
      S_IDLE: begin
        if (cmd == C_EX || cmd == C_DEP)        maddr = mas;
        else if (cmd == C_EXN || cmd == C_DEPN) maddr = ma + 18'd1;
        mwe = (cmd == C_DEP) || (cmd == C_DEPN);
      end
      S_IND: begin
        maddr = e;
        xa    = rdata[21:18];
      end
      S_EXEC: begin
        maddr = e;
        mwe   = (ir.op == OP_MOVEM);
        mwd   = acdata;
        ffwe  = (ir.op == OP_MOVEI) || (ir.op == OP_MOVE && !viol);
      end
      default: ;
    endcase
  end

  pdp6_mem #(.CORE_AW(CORE_AW)) u_mem (
    .clk(clk), .addr(maddr), .we(mwe), .wdata(mwd), .rdata(rdata), .viol(viol),
    .user_mode(user_mode), .pr(pr), .rlr(rlr), .xa(xa), .xdata(xdata),
    .aca(ir.ac), .acdata(acdata), .ffwe(ffwe), .ffwa(ir.ac), .ffwd(ffwd)
  );

  always_ff @(posedge clk) begin
    if (reset || sw_power) begin
      keys_q <= '0; state <= S_IDLE; run <= 1'b0; pc <= '0; ma <= '0; mb <= '0; pv <= 1'b0;
      ir <= '0; e <= '0; xct <= 1'b0; stop_req <= 1'b0; astop <= 1'b0;
    end else begin
      keys_q <= keys;
      if (run && (p_istop || p_mstop)) stop_req <= 1'b1;
      case (state)
        S_IDLE: case (cmd)
          C_START: begin pc <= mas; pv <= 1'b0; run <= 1'b1; state <= S_FETCH; end
          C_CONT:  begin run <= 1'b1; state <= S_FETCH; end
          C_EXEC:  begin ir <= datasw; xct <= 1'b1; state <= S_EA; end
          C_EX, C_EXN, C_DEP, C_DEPN: begin
            ma <= maddr;
            if (viol) pv <= 1'b1;
            else      mb <= (cmd == C_EX || cmd == C_EXN) ? rdata : datasw;
          end
          default: ;
        endcase
        S_FETCH: begin
          ma <= pc;
          if (viol) begin
            pv <= 1'b1; run <= 1'b0; state <= S_IDLE; stop_req <= 1'b0; astop <= 1'b0;
          end else begin
            mb <= rdata; ir <= rdata; state <= S_EA;
            if (hit) astop <= 1'b1;
          end
        end
        S_EA: begin
          e     <= calc_e(ir, xdata);
          state <= ir.i ? S_IND : S_EXEC;
        end
        S_IND: begin
          ma <= e;
          if (viol) begin
            pv <= 1'b1; run <= 1'b0; state <= S_IDLE; xct <= 1'b0; stop_req <= 1'b0; astop <= 1'b0;
          end else begin
            mb <= rdata; e <= calc_e(rdata, xdata);
            state <= rdata[22] ? S_IND : S_EXEC;
            if (hit) astop <= 1'b1;
          end
        end
        S_EXEC: begin
          if (mem_op) begin
            ma <= e;
            if (viol) pv <= 1'b1;
            else      mb <= (ir.op == OP_MOVE) ? rdata : acdata;
          end
          if (!xct) pc <= (ir.op == OP_JRST) ? e : pc + 18'd1;
          // A stop request arriving on the boundary clock beats the next fetch.
          if (xct || halt_op || stop_now || (mem_op && (hit || viol))) begin
            run <= 1'b0; state <= S_IDLE;
          end else begin
            state <= S_FETCH;
          end
          xct <= 1'b0; stop_req <= 1'b0; astop <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pdp6_system.sv
// Self-checking bench for pdp6_system: console tables, hand sequences and
// randomized console-exec instructions against a shadow-memory model.
module tb_pdp6_system;
  localparam int AW = 14;
  localparam int K_START = 0, K_RDIN = 1, K_EXEC = 2, K_ISTOP = 3, K_EX = 4,
                 K_EXN = 5, K_DEP = 6, K_DEPN = 7;

  logic clk = 1'b0, reset = 1'b0;
  logic key_start = 0, key_read_in = 0, key_exec = 0, key_inst_cont = 0, key_mem_cont = 0;
  logic key_inst_stop = 0, key_mem_stop = 0, key_ex = 0, key_ex_nxt = 0, key_dep = 0;
  logic key_dep_nxt = 0, key_io_reset = 0, sw_power = 0, sw_addr_stop = 0;
  logic [35:0] datasw = '0;
  logic [17:0] mas = '0;
  logic user_mode = 0;
  logic [7:0] pr = '0, rlr = '0;
  logic sw_repeat = 0, sw_mem_disable = 0, sw_split_cyc = 0, sw_rim_maint = 0;
  logic sw_repeat_bypass = 0, sw_art3_maint = 0, sw_sct_maint = 0;
  logic run, pv;
  logic [17:0] pc, ma;
  logic [35:0] mb;

  always #5 clk = ~clk;

  pdp6_system #(.CORE_AW(AW)) dut (
    .clk(clk), .reset(reset), .key_start(key_start), .key_read_in(key_read_in),
    .key_exec(key_exec), .key_inst_cont(key_inst_cont), .key_mem_cont(key_mem_cont),
    .key_inst_stop(key_inst_stop), .key_mem_stop(key_mem_stop), .key_ex(key_ex),
    .key_ex_nxt(key_ex_nxt), .key_dep(key_dep), .key_dep_nxt(key_dep_nxt),
    .key_io_reset(key_io_reset), .sw_power(sw_power), .sw_addr_stop(sw_addr_stop),
    .datasw(datasw), .mas(mas), .user_mode(user_mode), .pr(pr), .rlr(rlr),
    .sw_repeat(sw_repeat), .sw_mem_disable(sw_mem_disable), .sw_split_cyc(sw_split_cyc),
    .sw_rim_maint(sw_rim_maint), .sw_repeat_bypass(sw_repeat_bypass),
    .sw_art3_maint(sw_art3_maint), .sw_sct_maint(sw_sct_maint),
    .run(run), .pc(pc), .ma(ma), .mb(mb), .pv(pv)
  );

  // Shadow of the two memories, kept in step with every preload and model write.
  logic [35:0] mff [0:15];
  logic [35:0] mcore [0:(1<<AW)-1];
  int nvec = 0, nmis = 0;

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %o, expected %o", nm, act, exp);
    end
  endtask

  function automatic logic [35:0] mrd(input logic [17:0] a);
    return (a < 18'd16) ? mff[a[3:0]] : mcore[a[AW-1:0]];
  endfunction

  task automatic mwr(input logic [17:0] a, input logic [35:0] w);
    if (a < 18'd16) mff[a[3:0]] = w; else mcore[a[AW-1:0]] = w;
  endtask

  task automatic poke(input logic [17:0] a, input logic [35:0] w);
    if (a < 18'd16) dut.u_mem.ff[a[3:0]] <= w; else dut.u_mem.core[a[AW-1:0]] <= w;
    mwr(a, w);
  endtask

  function automatic logic [35:0] dut_rd(input logic [17:0] a);
    return (a < 18'd16) ? dut.u_mem.ff[a[3:0]] : dut.u_mem.core[a[AW-1:0]];
  endfunction

  // Effective address straight from the addressing rules, following indirection.
  function automatic logic [17:0] mea(input logic [35:0] w);
    logic [35:0] cw = w;
    logic [17:0] ea = '0;
    for (int lvl = 0; lvl < 64; lvl++) begin
      ea = cw[17:0] + ((cw[21:18] != 4'd0) ? mff[cw[21:18]][17:0] : 18'd0);
      if (!cw[22]) break;
      cw = mrd(ea);
    end
    return ea;
  endfunction

  function automatic logic [35:0] rnd_word();
    logic [63:0] r = {$urandom(), $urandom()};
    logic [35:0] w = r[35:0];
    w[22] = 1'b0;
    return w;
  endfunction

  task automatic set_key(input int k, input logic v);
    case (k)
      K_START: key_start = v;
      K_RDIN:  key_read_in = v;
      K_EXEC:  key_exec = v;
      K_ISTOP: key_inst_stop = v;
      K_EX:    key_ex = v;
      K_EXN:   key_ex_nxt = v;
      K_DEP:   key_dep = v;
      default: key_dep_nxt = v;
    endcase
  endtask

  task automatic press(input int k);
    set_key(k, 1'b1);
    @(posedge clk); #1;
    set_key(k, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic wait_halt(input int budget, input string nm);
    int n = 0;
    while (run === 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " halted"}, {35'b0, run}, 36'd0);
  endtask

  task automatic init_mem();
    for (int a = 0; a < 16; a++) poke(18'(a), rnd_word());
    for (int a = 16; a < (1<<AW); a++) poke(18'(a), rnd_word());
    @(posedge clk); #1;
  endtask

  typedef struct {
    int          kind;
    logic [17:0] mas;
    logic [35:0] dsw;
    logic [17:0] ema;
    logic [35:0] emb;
  } cvec_t;

  typedef struct {
    logic [35:0] ins;
    logic [17:0] loc;
    logic [35:0] exp;
  } evec_t;

  cvec_t cv [7];
  evec_t ev [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [35:0] w;
    logic [17:0] e;
    logic [8:0]  op;
    logic [3:0]  ac;
    int          n;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset run", {35'b0, run}, 36'd0);
    chk("reset pc", {18'b0, pc}, 36'd0);
    chk("reset ma", {18'b0, ma}, 36'd0);
    chk("reset mb", mb, 36'd0);
    chk("reset pv", {35'b0, pv}, 36'd0);

    init_mem();

    // Read-in of a short program: MOVEI 1,@104(4) then a halting opcode.
    poke(18'o4, 36'o000000010304);
    poke(18'o0, 36'o000000000042);
    poke(18'o20, 36'o201064000104);
    poke(18'o21, 36'o000000000000);
    poke(18'o10410, 36'o000000000333);
    poke(18'o37777, 36'o123456701234);
    @(posedge clk); #1;
    mas = 18'o20;
    press(K_RDIN);
    chk("readin run", {35'b0, run}, 36'd1);
    wait_halt(50, "readin");
    chk("readin ff1", dut.u_mem.ff[1], 36'o333);
    chk("readin pc", {18'b0, pc}, 36'o22);

    cv[0] = '{K_DEP,  18'o20,     36'o111777222666, 18'o20,     36'o111777222666};
    cv[1] = '{K_EXN,  18'o0,      36'o0,            18'o21,     36'o0};
    cv[2] = '{K_EX,   18'o4,      36'o0,            18'o4,      36'o000000010304};
    cv[3] = '{K_DEPN, 18'o0,      36'o555000000005, 18'o5,      36'o555000000005};
    cv[4] = '{K_EX,   18'o20,     36'o0,            18'o20,     36'o111777222666};
    cv[5] = '{K_EX,   18'o777777, 36'o0,            18'o777777, 36'o123456701234};
    cv[6] = '{K_EXN,  18'o0,      36'o0,            18'o0,      36'o42};
    for (int i = 0; i < 7; i++) begin
      mas = cv[i].mas;
      datasw = cv[i].dsw;
      press(cv[i].kind);
      chk($sformatf("console[%0d] ma", i), {18'b0, ma}, {18'b0, cv[i].ema});
      chk($sformatf("console[%0d] mb", i), mb, cv[i].emb);
      if (cv[i].kind == K_DEP || cv[i].kind == K_DEPN) mwr(cv[i].ema, cv[i].dsw);
    end
    chk("dep core20", dut.u_mem.core[20'o20], 36'o111777222666);
    chk("depnxt ff5", dut.u_mem.ff[5], 36'o555000000005);

    // Console exec: MOVEI, indexed, MOVE, MOVEM, two-level indirect, index wrap.
    poke(18'o60, 36'o000020000061);
    poke(18'o61, 36'o000000000444);
    poke(18'o7, 36'o000000777777);
    @(posedge clk); #1;
    ev[0] = '{36'o201040000777, 18'o1,  36'o777};
    ev[1] = '{36'o201104000005, 18'o2,  36'o010311};
    ev[2] = '{36'o200140000020, 18'o3,  36'o111777222666};
    ev[3] = '{36'o202140000050, 18'o50, 36'o111777222666};
    ev[4] = '{36'o201320000060, 18'o6,  36'o444};
    ev[5] = '{36'o201407000002, 18'o10, 36'o1};
    for (int i = 0; i < 6; i++) begin
      datasw = ev[i].ins;
      press(K_EXEC);
      repeat (5) @(posedge clk);
      #1;
      chk($sformatf("exec[%0d] result", i), dut_rd(ev[i].loc), ev[i].exp);
      chk($sformatf("exec[%0d] pc", i), {18'b0, pc}, 36'o22);
      chk($sformatf("exec[%0d] run", i), {35'b0, run}, 36'd0);
    end

    // Randomized single instructions through the exec key.
    init_mem();
    for (int i = 0; i < 40; i++) begin
      n  = $urandom_range(0, 2);
      op = (n == 0) ? 9'o200 : (n == 1) ? 9'o201 : 9'o202;
      ac = 4'($urandom_range(0, 15));
      w  = {op, ac, 1'b0, 4'd0, 18'd0};
      w[22] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) w[21:18] = 4'($urandom_range(1, 15));
      w[17:0] = ($urandom_range(0, 1) == 1) ? 18'($urandom_range(0, 'o77))
                                            : 18'($urandom_range(0, 'o777777));
      e = mea(w);
      if (op == 9'o200)      mff[ac] = mrd(e);
      else if (op == 9'o201) mff[ac] = {18'b0, e};
      else                   mwr(e, mff[ac]);
      datasw = w;
      press(K_EXEC);
      repeat (4) @(posedge clk);
      #1;
      if (op == 9'o202) chk($sformatf("rand[%0d] movem %o", i, w), dut_rd(e), mrd(e));
      else              chk($sformatf("rand[%0d] ac %o", i, w), dut.u_mem.ff[ac], mff[ac]);
    end
    for (int a = 0; a < 16; a++) chk($sformatf("rand ff[%0d]", a), dut.u_mem.ff[a], mff[a]);

    // Stop key against a JRST 0,20 loop.
    poke(18'o20, 36'o254000000020);
    @(posedge clk); #1;
    mas = 18'o20;
    press(K_START);
    repeat ($urandom_range(0, 6)) @(posedge clk);
    #1 key_inst_stop = 1'b1;
    for (int k = 0; k < 4 && run; k++) begin
      @(posedge clk); #1;
    end
    key_inst_stop = 1'b0;
    chk("stop run", {35'b0, run}, 36'd0);
    chk("stop pc", {18'b0, pc}, 36'o20);

    // Address stop on the fetch of 201.
    poke(18'o200, 36'o201040000001);
    poke(18'o201, 36'o201100000002);
    poke(18'o202, 36'o254000000200);
    @(posedge clk); #1;
    mas = 18'o200;
    press(K_START);
    mas = 18'o201;
    sw_addr_stop = 1'b1;
    wait_halt(30, "addr stop");
    chk("addr stop pc", {18'b0, pc}, 36'o202);
    sw_addr_stop = 1'b0;

    // Power clear while running aborts at once.
    mas = 18'o20;
    press(K_START);
    repeat (3) @(posedge clk);
    #1 sw_power = 1'b1;
    @(posedge clk); #1 sw_power = 1'b0;
    chk("power run", {35'b0, run}, 36'd0);
    chk("power pc", {18'b0, pc}, 36'd0);
    chk("power ma", {18'b0, ma}, 36'd0);

    user_mode = 1'b1; pr = 8'o3; rlr = 8'o2;
`ifdef PDP6_RELOC_EN
    mas = 18'o10000;
    press(K_START);
    wait_halt(20, "reloc viol");
    chk("reloc pv", {35'b0, pv}, 36'd1);
    poke(18'o4100, 36'o201040000555);
    poke(18'o4101, 36'o0);
    @(posedge clk); #1;
    mas = 18'o100;
    press(K_START);
    wait_halt(20, "reloc run");
    chk("reloc pv clear", {35'b0, pv}, 36'd0);
    chk("reloc ff1", dut.u_mem.ff[1], 36'o555);
    chk("reloc pc", {18'b0, pc}, 36'o102);
`else
    poke(18'o10000, 36'o201040000555);
    poke(18'o10001, 36'o0);
    @(posedge clk); #1;
    mas = 18'o10000;
    press(K_START);
    wait_halt(20, "user run");
    chk("user pv", {35'b0, pv}, 36'd0);
    chk("user ff1", dut.u_mem.ff[1], 36'o555);
    chk("user pc", {18'b0, pc}, 36'o10002);
`endif
    user_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
